gat_bram_loader: RTL and testbench

//  Host-side writer for the GAT accelerator's three input BRAM load ports (H data, H node_info, weight).

---
 rtl/gat_bram_loader.sv | 222 ++++++++++++++++++++++
 tb/tb_gat_bram_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gat_bram_loader.sv
// Splits one 32-bit valid/ready word stream into the H data, H node_info and weight BRAM write ports.
// Optional running checksum output is enabled by defining GAT_LOADER_CHECKSUM_EN.
module gat_bram_loader #(
    parameter int TOP_WIDTH       = 32,
    parameter int H_DATA_DEPTH    = 242101,
    parameter int NODE_INFO_DEPTH = 13264,
    parameter int WEIGHT_DEPTH    = 22928,
    localparam int H_DATA_ADDR_W    = (H_DATA_DEPTH    > 1) ? $clog2(H_DATA_DEPTH)    : 1,
    localparam int NODE_INFO_ADDR_W = (NODE_INFO_DEPTH > 1) ? $clog2(NODE_INFO_DEPTH) : 1,
    localparam int WEIGHT_ADDR_W    = (WEIGHT_DEPTH    > 1) ? $clog2(WEIGHT_DEPTH)    : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [TOP_WIDTH-1:0]        s_tdata,
    input  logic                        s_tvalid,
    output logic                        s_tready,
    input  logic                        s_tlast,
    output logic [TOP_WIDTH-1:0]        h_data_bram_din,
    output logic                        h_data_bram_ena,
    output logic                        h_data_bram_wea,
    output logic [H_DATA_ADDR_W+1:0]    h_data_bram_addra,
    output logic [TOP_WIDTH-1:0]        h_node_info_bram_din,
    output logic                        h_node_info_bram_ena,
    output logic                        h_node_info_bram_wea,
    output logic [NODE_INFO_ADDR_W+1:0] h_node_info_bram_addra,
    output logic [TOP_WIDTH-1:0]        wgt_bram_din,
    output logic                        wgt_bram_ena,
    output logic                        wgt_bram_wea,
    output logic [WEIGHT_ADDR_W+1:0]    wgt_bram_addra,
    output logic                        h_data_bram_load_done,
    output logic                        h_node_info_bram_load_done,
    output logic                        wgt_bram_load_done,
    output logic                        busy,
    output logic                        err
`ifdef GAT_LOADER_CHECKSUM_EN
    ,output logic [TOP_WIDTH-1:0]       checksum
`endif
);

    localparam int IDX_W_HN = (H_DATA_ADDR_W > NODE_INFO_ADDR_W) ? H_DATA_ADDR_W : NODE_INFO_ADDR_W;
    localparam int IDX_W    = (IDX_W_HN > WEIGHT_ADDR_W) ? IDX_W_HN : WEIGHT_ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_H  = 3'd1,
        S_LOAD_NI = 3'd2,
        S_LOAD_W  = 3'd3,
        S_DONE    = 3'd4,
        S_ERR     = 3'd5
    } state_e;

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            word_idx_q, word_idx_d;
    logic                        err_q, err_d;
    logic                        h_done_q, h_done_d, ni_done_q, ni_done_d, w_done_q, w_done_d;
    logic                        h_ena_q, h_ena_d, ni_ena_q, ni_ena_d, w_ena_q, w_ena_d;
    logic [TOP_WIDTH-1:0]        h_din_q, h_din_d, ni_din_q, ni_din_d, w_din_q, w_din_d;
    logic [H_DATA_ADDR_W+1:0]    h_addr_q, h_addr_d;
    logic [NODE_INFO_ADDR_W+1:0] ni_addr_q, ni_addr_d;
    logic [WEIGHT_ADDR_W+1:0]    w_addr_q, w_addr_d;
    logic [TOP_WIDTH-1:0]        checksum_q, checksum_d;
    logic                        hs_s, region_last_s, stream_final_s;

    assign s_tready = (state_q == S_LOAD_H) || (state_q == S_LOAD_NI) || (state_q == S_LOAD_W);
    assign busy     = s_tready;
    assign hs_s     = s_tvalid & s_tready;

    // Decode whether the current word is the last of its region / of the whole stream
    always_comb begin
        region_last_s = 1'b0;
        case (state_q)
            S_LOAD_H:  region_last_s = (word_idx_q == IDX_W'(H_DATA_DEPTH - 1));
            S_LOAD_NI: region_last_s = (word_idx_q == IDX_W'(NODE_INFO_DEPTH - 1));
            S_LOAD_W:  region_last_s = (word_idx_q == IDX_W'(WEIGHT_DEPTH - 1));
            default:   region_last_s = 1'b0;
        endcase
        stream_final_s = (state_q == S_LOAD_W) && region_last_s;
    end

    // Next-state, word counter, framing and write-port computation
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        err_d      = err_q;
        h_done_d   = h_done_q;
        ni_done_d  = ni_done_q;
        w_done_d   = w_done_q;
        checksum_d = checksum_q;
        h_ena_d    = 1'b0;
        ni_ena_d   = 1'b0;
        w_ena_d    = 1'b0;
        h_din_d    = h_din_q;
        ni_din_d   = ni_din_q;
        w_din_d    = w_din_q;
        h_addr_d   = h_addr_q;
        ni_addr_d  = ni_addr_q;
        w_addr_d   = w_addr_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LOAD_H;
                    word_idx_d = '0;
                    err_d      = 1'b0;
                    h_done_d   = 1'b0;
                    ni_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    checksum_d = '0;
                end else begin
                    state_d = state_q;
                end
            end
            S_LOAD_H, S_LOAD_NI, S_LOAD_W: begin
                if (hs_s) begin
                    checksum_d = checksum_q + s_tdata;
                    // tlast must coincide exactly with the final weight word
                    if (s_tlast != stream_final_s) begin
                        state_d    = S_ERR;
                        err_d      = 1'b1;
                        word_idx_d = '0;
                    end else if (region_last_s) begin
                        word_idx_d = '0;
                        case (state_q)
                            S_LOAD_H:  begin state_d = S_LOAD_NI; h_done_d  = 1'b1; end
                            S_LOAD_NI: begin state_d = S_LOAD_W;  ni_done_d = 1'b1; end
                            default:   begin state_d = S_DONE;    w_done_d  = 1'b1; end
                        endcase
                    end else begin
                        word_idx_d = word_idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (hs_s) begin
            case (state_q)
                S_LOAD_H: begin
                    h_ena_d  = 1'b1;
                    h_din_d  = s_tdata;
                    h_addr_d = {word_idx_q[H_DATA_ADDR_W-1:0], 2'b00};
                end
                S_LOAD_NI: begin
                    ni_ena_d  = 1'b1;
                    ni_din_d  = s_tdata;
                    ni_addr_d = {word_idx_q[NODE_INFO_ADDR_W-1:0], 2'b00};
                end
                S_LOAD_W: begin
                    w_ena_d  = 1'b1;
                    w_din_d  = s_tdata;
                    w_addr_d = {word_idx_q[WEIGHT_ADDR_W-1:0], 2'b00};
                end
                default: h_ena_d = 1'b0;
            endcase
        end else begin
            h_ena_d = 1'b0;
        end
    end

    // State and output registers; reset aborts any load in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            word_idx_q <= '0;
            err_q      <= 1'b0;
            h_done_q   <= 1'b0;
            ni_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            checksum_q <= '0;
            h_ena_q    <= 1'b0;
            ni_ena_q   <= 1'b0;
            w_ena_q    <= 1'b0;
            h_din_q    <= '0;
            ni_din_q   <= '0;
            w_din_q    <= '0;
            h_addr_q   <= '0;
            ni_addr_q  <= '0;
            w_addr_q   <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            err_q      <= err_d;
            h_done_q   <= h_done_d;
            ni_done_q  <= ni_done_d;
            w_done_q   <= w_done_d;
            checksum_q <= checksum_d;
            h_ena_q    <= h_ena_d;
            ni_ena_q   <= ni_ena_d;
            w_ena_q    <= w_ena_d;
            h_din_q    <= h_din_d;
            ni_din_q   <= ni_din_d;
            w_din_q    <= w_din_d;
            h_addr_q   <= h_addr_d;
            ni_addr_q  <= ni_addr_d;
            w_addr_q   <= w_addr_d;
        end
    end

    assign h_data_bram_din            = h_din_q;
    assign h_data_bram_ena            = h_ena_q;
    assign h_data_bram_wea            = h_ena_q;
    assign h_data_bram_addra          = h_addr_q;
    assign h_node_info_bram_din       = ni_din_q;
    assign h_node_info_bram_ena       = ni_ena_q;
    assign h_node_info_bram_wea       = ni_ena_q;
    assign h_node_info_bram_addra     = ni_addr_q;
    assign wgt_bram_din               = w_din_q;
    assign wgt_bram_ena               = w_ena_q;
    assign wgt_bram_wea               = w_ena_q;
    assign wgt_bram_addra             = w_addr_q;
    assign h_data_bram_load_done      = h_done_q;
    assign h_node_info_bram_load_done = ni_done_q;
    assign wgt_bram_load_done         = w_done_q;
    assign err                        = err_q;
`ifdef GAT_LOADER_CHECKSUM_EN
    assign checksum                   = checksum_q;
`endif

endmodule

// File: tb/tb_gat_bram_loader.sv
// Directed bench for gat_bram_loader with small depths (H=4, NI=3, W=2) and a position-based reference model.
module tb_gat_bram_loader;
    localparam int HD = 4, ND = 3, WD = 2, TOT = 9;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [31:0] s_tdata = 32'd0;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0;
    logic        s_tready, busy, err;
    logic [31:0] h_din, ni_din, w_din;
    logic        h_ena, h_wea, ni_ena, ni_wea, w_ena, w_wea;
    logic [3:0]  h_addr, ni_addr;
    logic [2:0]  w_addr;
    logic        h_done, ni_done, w_done;
`ifdef GAT_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    gat_bram_loader #(.TOP_WIDTH(32), .H_DATA_DEPTH(HD), .NODE_INFO_DEPTH(ND), .WEIGHT_DEPTH(WD)) dut (
        .clk(clk), .rst(rst), .start(start),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .h_data_bram_din(h_din), .h_data_bram_ena(h_ena), .h_data_bram_wea(h_wea), .h_data_bram_addra(h_addr),
        .h_node_info_bram_din(ni_din), .h_node_info_bram_ena(ni_ena), .h_node_info_bram_wea(ni_wea),
        .h_node_info_bram_addra(ni_addr),
        .wgt_bram_din(w_din), .wgt_bram_ena(w_ena), .wgt_bram_wea(w_wea), .wgt_bram_addra(w_addr),
        .h_data_bram_load_done(h_done), .h_node_info_bram_load_done(ni_done), .wgt_bram_load_done(w_done),
        .busy(busy), .err(err)
`ifdef GAT_LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: tracks the global stream position and derives region/offset from it
    int          m_pos = 0;
    bit          m_active = 1'b0, m_err = 1'b0;
    bit          m_done[3] = '{1'b0, 1'b0, 1'b0};
    bit          e_ena[3]  = '{1'b0, 1'b0, 1'b0};
    logic [31:0] e_din[3]  = '{32'd0, 32'd0, 32'd0};
    logic [31:0] e_addr[3] = '{32'd0, 32'd0, 32'd0};
    logic [31:0] m_sum = 32'd0;
    int          base[3] = '{0, HD, HD + ND};
    int          dep[3]  = '{HD, ND, WD};

    function automatic int region_of(input int p);
        if (p < HD) return 0;
        else if (p < HD + ND) return 1;
        else return 2;
    endfunction

    task automatic model_step();
        int r;
        bit fin;
        if (rst) begin
            m_pos = 0; m_active = 1'b0; m_err = 1'b0; m_sum = 32'd0;
            for (int k = 0; k < 3; k++) begin
                m_done[k] = 1'b0; e_ena[k] = 1'b0; e_din[k] = 32'd0; e_addr[k] = 32'd0;
            end
        end else begin
            for (int k = 0; k < 3; k++) e_ena[k] = 1'b0;
            if (!m_active && start) begin
                m_active = 1'b1; m_err = 1'b0; m_pos = 0; m_sum = 32'd0;
                for (int k = 0; k < 3; k++) m_done[k] = 1'b0;
            end else if (m_active && s_tvalid) begin
                r = region_of(m_pos);
                e_ena[r]  = 1'b1;
                e_din[r]  = s_tdata;
                e_addr[r] = 32'((m_pos - base[r]) * 4);
                m_sum     = m_sum + s_tdata;
                fin       = (m_pos == TOT - 1);
                if (s_tlast != fin) begin
                    m_err = 1'b1; m_active = 1'b0;
                end else begin
                    if (m_pos == base[r] + dep[r] - 1) m_done[r] = 1'b1;
                    if (fin) m_active = 1'b0;
                end
                m_pos++;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    logic [2:0]  d_ena, d_wea, d_done;
    logic [31:0] d_din[3], d_addr[3];
    assign d_ena  = {w_ena, ni_ena, h_ena};
    assign d_wea  = {w_wea, ni_wea, h_wea};
    assign d_done = {w_done, ni_done, h_done};
    assign d_din[0] = h_din;  assign d_din[1] = ni_din;  assign d_din[2] = w_din;
    assign d_addr[0] = 32'(h_addr); assign d_addr[1] = 32'(ni_addr); assign d_addr[2] = 32'(w_addr);

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("tready", 32'(s_tready), 32'(m_active));
            chk("busy", 32'(busy), 32'(m_active));
            chk("err", 32'(err), 32'(m_err));
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("done%0d", k), 32'(d_done[k]), 32'(m_done[k]));
                chk($sformatf("ena%0d", k), 32'(d_ena[k]), 32'(e_ena[k]));
                chk($sformatf("wea%0d", k), 32'(d_wea[k]), 32'(e_ena[k]));
                chk($sformatf("din%0d", k), d_din[k], e_din[k]);
                chk($sformatf("addr%0d", k), d_addr[k], e_addr[k]);
            end
`ifdef GAT_LOADER_CHECKSUM_EN
            chk("checksum", checksum, m_sum);
`endif
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input bit last, input bit gap);
        int  n;
        bit  rdy;
        if (gap) begin
            s_tvalid = 1'b0; s_tlast = 1'b0;
            @(posedge clk); #1;
        end
        s_tdata = d; s_tlast = last; s_tvalid = 1'b1;
        n = 0;
        do begin
            rdy = s_tready;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 20);
        chk("send_handshake", 32'(rdy), 32'd1);
    endtask

    task automatic idle_bus();
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        chk("rst_tready", 32'(s_tready), 32'd0);
        chk("rst_hdin", h_din, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // T1: back-to-back stream
        pulse_start();
        for (int i = 1; i <= TOT; i++) send(32'(i), i == TOT, 1'b0);
        chk("t1_wdin", w_din, 32'd9);
        chk("t1_waddr", 32'(w_addr), 32'd4);
        chk("t1_hdin", h_din, 32'd4);
        chk("t1_haddr", 32'(h_addr), 32'd12);
        chk("t1_nidin", ni_din, 32'd7);
        chk("t1_niaddr", 32'(ni_addr), 32'd8);
        chk("t1_done", 32'(d_done), 32'd7);
        chk("t1_err", 32'(err), 32'd0);
        idle_bus();
        repeat (2) @(posedge clk); #1;

        // T2: valid toggling
        pulse_start();
        for (int i = 1; i <= TOT; i++) send(32'(i), i == TOT, 1'b1);
        chk("t2_done", 32'(d_done), 32'd7);
        idle_bus();
        repeat (2) @(posedge clk); #1;

        // T3: early tlast on word 3
        pulse_start();
        send(32'd1, 1'b0, 1'b0);
        send(32'd2, 1'b0, 1'b0);
        send(32'd3, 1'b1, 1'b0);
        chk("t3_haddr", 32'(h_addr), 32'd8);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_tready", 32'(s_tready), 32'd0);
        chk("t3_done", 32'(d_done), 32'd0);
        s_tdata = 32'd4; s_tlast = 1'b0; s_tvalid = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("t3_no_write", 32'(h_ena), 32'd0);
        chk("t3_hdin_hold", h_din, 32'd3);
        idle_bus();

        // T4: missing tlast on final word
        pulse_start();
        for (int i = 1; i <= TOT; i++) send(32'(i), 1'b0, 1'b0);
        chk("t4_wdin", w_din, 32'd9);
        chk("t4_waddr", 32'(w_addr), 32'd4);
        chk("t4_wdone", 32'(w_done), 32'd0);
        chk("t4_err", 32'(err), 32'd1);
        idle_bus();
        @(posedge clk); #1;
        pulse_start();
        chk("t4_restart_err", 32'(err), 32'd0);
        chk("t4_restart_done", 32'(d_done), 32'd0);
        chk("t4_restart_busy", 32'(busy), 32'd1);

        // T5: reset after word 6, then a clean reload
        for (int i = 1; i <= 6; i++) send(32'(i), 1'b0, 1'b0);
        idle_bus();
        rst = 1'b1;
        #1;
        chk("t5_rst_nidin", ni_din, 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_done", 32'(d_done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        pulse_start();
        for (int i = 1; i <= TOT; i++) send(32'(i), i == TOT, 1'b0);
        chk("t5_waddr", 32'(w_addr), 32'd4);
        chk("t5_done", 32'(d_done), 32'd7);
`ifdef GAT_LOADER_CHECKSUM_EN
        chk("t6_sum45", checksum, 32'd45);
`endif
        idle_bus();
        @(posedge clk); #1;

`ifdef GAT_LOADER_CHECKSUM_EN
        // T6: wraparound of the checksum
        pulse_start();
        for (int i = 1; i <= TOT; i++) send(32'hFFFF_FFFF, i == TOT, 1'b0);
        idle_bus();
        @(posedge clk); #1;
        chk("t6_sumwrap", checksum, 32'hFFFF_FFF7);
`endif

        repeat (3) @(posedge clk); #1;
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
